// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Purpose : Shared defaults and well-known register numbers for the MIPS
//           register file and its pending-write scoreboard.
// Contents: REGFILE_DATA_W / REGFILE_NUM_REGS / REGFILE_ADDR_W defaults,
//           REG_ZERO (hardwired-zero register) and REG_RA (return address).
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int REGFILE_DATA_W   = 32;
  localparam int REGFILE_NUM_REGS = 32;
  localparam int REGFILE_ADDR_W   = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// Purpose : One busy bit per architectural register, marking registers whose
//           producing instruction has issued but not yet written back. Also
//           keeps a registered population count of the busy bits and looks up
//           the busy state of each read port's source register.
// Ports   : clk, rst        clock, synchronous active-high reset
//           iss_en/iss_addr  decode issued a writer of iss_addr (sets busy)
//           wr_en/wr_addr    writeback of wr_addr (clears busy)
//           rd_addr          NUM_RD packed read addresses
//           rd_busy          per-port busy flag (combinational)
//           busy_cnt         number of busy registers (registered)
// ---------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = REGFILE_NUM_REGS,
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W:0] CNT_ONE    = (ADDR_W+1)'(1);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                set_ok, clr_ok, set_rise, clr_fall;

  always_comb begin
    set_ok = iss_en && ({1'b0, iss_addr} < NUM_REGS_W)
             && !(ZERO_REG && (iss_addr == '0));
    clr_ok = wr_en && ({1'b0, wr_addr} < NUM_REGS_W);

    // Count only real bit transitions. A clear that collides with a set on
    // the same register never reaches 0, so it does not decrement.
    set_rise = set_ok && !busy_q[iss_addr];
    clr_fall = clr_ok && busy_q[wr_addr] && !(set_ok && (iss_addr == wr_addr));

    // Clear first, then set, so a same-register collision leaves it busy
    // for the newly issued producer.
    busy_d = busy_q;
    if (clr_ok) busy_d[wr_addr] = 1'b0;
    if (set_ok) busy_d[iss_addr] = 1'b1;

    cnt_d = cnt_q;
    if (set_rise && !clr_fall)      cnt_d = cnt_q + CNT_ONE;
    else if (clr_fall && !set_rise) cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  // A port whose source is being written this cycle gets the data forwarded,
  // so it is not reported as a hazard when bypassing is enabled.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_busy
    logic [ADDR_W-1:0] rd_a;
    assign rd_a = rd_addr[gi*ADDR_W +: ADDR_W];
    assign rd_busy[gi] = ({1'b0, rd_a} < NUM_REGS_W)
                         && !(ZERO_REG && (rd_a == '0))
                         && busy_q[rd_a]
                         && !(BYPASS && clr_ok && (wr_addr == rd_a));
  end

endmodule

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
// Purpose : Multi-read-port register file with one synchronous write port,
//           optional hardwired-zero r0, optional write-to-read bypass, and a
//           pending-write scoreboard for RAW hazard stalls in decode.
// Ports   : clk, rst                  clock, synchronous active-high reset
//           wr_en/wr_addr/wr_data     writeback port
//           rd_addr/rd_data/rd_busy   NUM_RD packed combinational read ports
//           iss_en/iss_addr           decode issue of a register writer
//           busy_cnt                  number of registers with pending writes
// ---------------------------------------------------------------------------
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int NUM_REGS = REGFILE_NUM_REGS,
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_ok;

  // Writes to r0 (when hardwired) and to nonexistent registers are dropped.
  assign wr_ok = wr_en && ({1'b0, wr_addr} < NUM_REGS_W)
                 && !(ZERO_REG && (wr_addr == '0));

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    assign regs_d[gi] = (wr_ok && (wr_addr == ADDR_W'(gi))) ? wr_data : regs_q[gi];

    always_ff @(posedge clk) begin
      if (rst) regs_q[gi] <= '0;
      else     regs_q[gi] <= regs_d[gi];
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_port
    logic [ADDR_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_val;

    assign rd_a = rd_addr[gi*ADDR_W +: ADDR_W];

    always_comb begin
      rd_val = '0;
      if (({1'b0, rd_a} < NUM_REGS_W) && !(ZERO_REG && (rd_a == '0))) begin
        if (BYPASS && wr_ok && (wr_addr == rd_a)) rd_val = wr_data;
        else                                      rd_val = regs_q[rd_a];
      end
    end

    assign rd_data[gi*DATA_W +: DATA_W] = rd_val;
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .busy_cnt (busy_cnt)
  );

endmodule
